// File: rtl/logical_shift_right_seq.sv
// Sequential logical right shifter: accepts a word and shift amount, shifts right one bit per
// clock with zero fill, then holds the result behind a valid/ready output handshake.
module logical_shift_right_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] di_i,
  input  logic [SHW-1:0]   sel_i,
  output logic [WIDTH-1:0] o_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;

  logic accept;
  logic last_shift;

  assign accept     = (state_q == StIdle) && in_valid_i;
  assign last_shift = (state_q == StShift) && (cnt_q == SHW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d = (sel_i == '0) ? StHold : StShift;
        end
      end
      StShift: begin
        if (last_shift) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      StIdle:  in_ready_o = 1'b1;
      StShift: busy_o     = 1'b1;
      StHold: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: in_ready_o = 1'b0;
    endcase
  end

  // Datapath: shifting one bit per cycle naturally yields zero for sel >= WIDTH.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      shreg_d = di_i;
      cnt_d   = sel_i;
    end else if (state_q == StShift) begin
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      cnt_d   = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_o = shreg_q;

  // Design invariants
  a_cnt_nonzero_in_shift : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StShift) |-> (cnt_q != '0));
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StHold && !out_ready_i) |=> (state_q == StHold && $stable(shreg_q)));
  a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q inside {StIdle, StShift, StHold}));

endmodule
